// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: FSM states, instruction layout and ctrl encodings.
// The ERR state exists only when ALU_SEQ_TIMEOUT_EN is defined.
package alu_seq_pkg;

  localparam int INSTR_W      = 8;
  localparam int CTRL_LSB     = 6;
  localparam int A_LSB        = 4;
  localparam int B_LSB        = 2;
  localparam int REG_ADDR_LSB = 0;

  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;
  localparam logic [1:0] CTRL_OP2 = 2'b10;
  localparam logic [1:0] CTRL_OP3 = 2'b11;

`ifdef ALU_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_RETIRE = 3'd3,
    ST_FIN    = 3'd4,
    ST_ERR    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_RETIRE = 3'd3,
    ST_FIN    = 3'd4
  } state_t;
`endif

  typedef struct packed {
    logic [1:0] ctrl;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] reg_addr;
  } instr_t;

  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.ctrl     = raw[CTRL_LSB +: 2];
    d.a        = raw[A_LSB +: 2];
    d.b        = raw[B_LSB +: 2];
    d.reg_addr = raw[REG_ADDR_LSB +: 2];
    return d;
  endfunction

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store for the ALU op sequencer: unreset DEPTH x 8 array with a synchronous
// write port and a registered read whose output register doubles as the instruction register.
module alu_seq_prog_mem
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_r [DEPTH];
  logic [INSTR_W-1:0] rdata_r;

  // Program array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Instruction register, loaded only when a fetch is committed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= {INSTR_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/alu_op_sequencer.sv
// Fetch/decode/issue stage driving alu_with_memory from a small program store.
// Optional EXEC watchdog and ERR state are enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic          start,
  input  logic [AW-1:0] last_addr,
  input  logic          abort,
  input  logic          alu_done,
  output logic [1:0]    alu_a,
  output logic [1:0]    alu_b,
  output logic [1:0]    alu_ctrl,
  output logic [1:0]    alu_reg_addr,
  output logic          alu_reg_write,
  output logic          busy,
  output logic [AW-1:0] pc,
  output logic          seq_done,
  output logic [AW:0]   retired,
  output logic          timeout_err
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 2)) begin : g_param_check
    $error("alu_op_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end

  state_t         state_r;
  state_t         next_s;
  state_t         exec_stall_s;
  logic [AW-1:0]  pc_r;
  logic [AW-1:0]  last_r;
  logic [AW:0]    retired_r;
  logic           alu_reg_write_r;
  logic           busy_r;
  logic           seq_done_r;
  logic           exec_first_r;
  logic           mem_we_s;
  logic           mem_re_s;
  logic [7:0]     instr_raw_s;
  instr_t         instr_s;

  assign mem_we_s = prog_we && (state_r == ST_IDLE);
  assign mem_re_s = (state_r == ST_FETCH) && !abort;

  alu_seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we_s),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (mem_re_s),
    .raddr (pc_r),
    .rdata (instr_raw_s)
  );

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] exec_cnt_r;
  logic          timeout_err_r;

  // The stall target becomes ERR once the current EXEC cycle is the TIMEOUT-th.
  assign exec_stall_s = (exec_cnt_r == CW'(TIMEOUT - 1)) ? ST_ERR : ST_EXEC;

  // EXEC cycle counter and sticky watchdog flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt_r    <= {CW{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      if ((state_r == ST_EXEC) && (next_s == ST_EXEC)) begin
        exec_cnt_r <= exec_cnt_r + CW'(1'b1);
      end else begin
        exec_cnt_r <= {CW{1'b0}};
      end
      if ((state_r == ST_IDLE) && start) begin
        timeout_err_r <= 1'b0;
      end else if (next_s == ST_ERR) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign exec_stall_s = ST_EXEC;
  assign timeout_err  = 1'b0;
`endif

  // Next-state logic; abort wins over alu_done, and the first EXEC cycle ignores done.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_s = ST_FETCH;
        else       next_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (abort) next_s = ST_IDLE;
        else       next_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (abort)                          next_s = ST_IDLE;
        else if (!exec_first_r && alu_done) next_s = ST_RETIRE;
        else                                next_s = exec_stall_s;
      end
      ST_RETIRE: begin
        if (abort)               next_s = ST_IDLE;
        else if (pc_r == last_r) next_s = ST_FIN;
        else                     next_s = ST_FETCH;
      end
      ST_FIN: begin
        next_s = ST_IDLE;
      end
`ifdef ALU_SEQ_TIMEOUT_EN
      ST_ERR: begin
        if (abort) next_s = ST_IDLE;
        else       next_s = ST_ERR;
      end
`endif
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // State, program counter, retire count and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      pc_r            <= {AW{1'b0}};
      last_r          <= {AW{1'b0}};
      retired_r       <= {(AW + 1){1'b0}};
      alu_reg_write_r <= 1'b0;
      busy_r          <= 1'b0;
      seq_done_r      <= 1'b0;
      exec_first_r    <= 1'b1;
    end else begin
      state_r         <= next_s;
      alu_reg_write_r <= (next_s == ST_EXEC);
      busy_r          <= (next_s != ST_IDLE);
      seq_done_r      <= (next_s == ST_FIN);
      exec_first_r    <= (state_r != ST_EXEC);
      if ((state_r == ST_IDLE) && start) begin
        pc_r      <= {AW{1'b0}};
        retired_r <= {(AW + 1){1'b0}};
        last_r    <= last_addr;
      end else if ((state_r == ST_RETIRE) && !abort) begin
        retired_r <= retired_r + (AW + 1)'(1'b1);
        if (pc_r != last_r) begin
          pc_r <= pc_r + AW'(1'b1);
        end
      end
    end
  end

  assign instr_s       = decode_instr(instr_raw_s);
  assign alu_a         = instr_s.a;
  assign alu_b         = instr_s.b;
  assign alu_ctrl      = instr_s.ctrl;
  assign alu_reg_addr  = instr_s.reg_addr;
  assign alu_reg_write = alu_reg_write_r;
  assign busy          = busy_r;
  assign pc            = pc_r;
  assign seq_done      = seq_done_r;
  assign retired       = retired_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: random programs and ALU latencies, a queue of
// expected EXEC windows and seq_done pulses, and a negedge monitor that pops and compares.
module tb_alu_op_sequencer;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          start;
  logic [AW-1:0] last_addr;
  logic          abort = 1'b0;
  logic          alu_done = 1'b0;
  logic [1:0]    alu_a, alu_b, alu_ctrl, alu_reg_addr;
  logic          alu_reg_write, busy, seq_done, timeout_err;
  logic [AW-1:0] pc;
  logic [AW:0]   retired;

  alu_op_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .last_addr(last_addr), .abort(abort),
    .alu_done(alu_done), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_reg_addr(alu_reg_addr), .alu_reg_write(alu_reg_write), .busy(busy), .pc(pc),
    .seq_done(seq_done), .retired(retired), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    int         pc;
    int         len;
  } win_t;

  win_t       exp_q[$];
  int         done_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] prog_m [DEPTH];
  int         alu_mode = 0;   // 0: done after alu_lat EXEC cycles, 1: done always high, 2: never
  int         alu_lat = 2;
  bit         abort_req = 1'b0;
  bit         abort_arm = 1'b0;
  bit         mon_discard = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ALU responder: done after a programmable number of EXEC cycles; optional abort injection.
  int k = 0;
  always @(negedge clk) begin
    if (alu_reg_write) k = k + 1;
    else k = 0;
    case (alu_mode)
      1:       alu_done = 1'b1;
      2:       alu_done = 1'b0;
      default: alu_done = alu_reg_write && (k >= alu_lat);
    endcase
    abort = 1'b0;
    if (abort_req) begin
      abort = 1'b1;
      abort_req = 1'b0;
    end else if (abort_arm && alu_reg_write && (pc == 1) && alu_done) begin
      abort = 1'b1;
      abort_arm = 1'b0;
    end
  end

  // Monitor: pops expected EXEC windows and seq_done pulses as the DUT presents them.
  bit         prev_wr = 1'b0;
  bit         open = 1'b0;
  bit         held_valid = 1'b0;
  bit         expect_idle = 1'b0;
  int         cur_len = 0;
  int         exp_len = 0;
  logic [7:0] held = 8'h00;
  win_t       w;
  always @(negedge clk) begin
    if (mon_discard) begin
      open = 1'b0;
      held_valid = 1'b0;
      expect_idle = 1'b0;
      mon_discard = 1'b0;
    end else begin
      if (expect_idle) begin
        chk("busy_after_seq_done", busy, 1'b0);
        expect_idle = 1'b0;
      end
      if (seq_done) begin
        if (done_q.size() == 0) fail_now("unexpected_seq_done");
        else begin
          chk("retired_at_seq_done", retired, done_q.pop_front());
          chk("busy_at_seq_done", busy, 1'b1);
        end
        expect_idle = 1'b1;
      end
      if (alu_reg_write && !prev_wr) begin
        if (exp_q.size() == 0) fail_now("unexpected_exec_window");
        else begin
          w = exp_q.pop_front();
          chk("exec_fields", {alu_ctrl, alu_a, alu_b, alu_reg_addr}, w.instr);
          chk("exec_pc", pc, w.pc);
          held = w.instr;
          held_valid = 1'b1;
          exp_len = w.len;
          cur_len = 1;
          open = 1'b1;
        end
      end else if (alu_reg_write) begin
        cur_len++;
      end else begin
        if (prev_wr && open) begin
          chk("exec_len", cur_len, exp_len);
          open = 1'b0;
        end
        if (busy && held_valid) chk("operand_hold", {alu_ctrl, alu_a, alu_b, alu_reg_addr}, held);
      end
    end
    prev_wr = alu_reg_write;
  end

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [7:0] d);
    wait_neg();
    prog_we = 1'b1;
    prog_addr = AW'(addr);
    prog_data = d;
    wait_neg();
    prog_we = 1'b0;
    prog_m[addr] = d;
  endtask

  function automatic int exec_len_model();
    if (alu_mode == 1) return 2;
    if (alu_mode == 2) return TIMEOUT;
    return (alu_lat < 2) ? 2 : alu_lat;
  endfunction

  task automatic expect_prog(input int last, input int nwin, input bit with_done);
    win_t e;
    for (int i = 0; i < nwin; i++) begin
      e.instr = prog_m[i];
      e.pc = i;
      e.len = exec_len_model();
      exp_q.push_back(e);
    end
    if (with_done) done_q.push_back(last + 1);
  endtask

  task automatic run(input int last, input int nwin, input bit with_done, input bit disturb, input int budget);
    int n;
    expect_prog(last, nwin, with_done);
    wait_neg();
    start = 1'b1;
    last_addr = AW'(last);
    wait_neg();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    n = 0;
    while (busy && n < budget) begin
      wait_neg();
      n++;
      if (disturb) begin
        case (n)
          3: begin prog_we = 1'b1; prog_addr = AW'(2); prog_data = ~prog_m[2]; end
          4: prog_we = 1'b0;
          6: begin start = 1'b1; last_addr = AW'(0); end
          7: start = 1'b0;
          default: ;
        endcase
      end
    end
    start = 1'b0;
    prog_we = 1'b0;
    if (busy) fail_now("run_cycle_budget_expired");
  endtask

  initial begin
    int n;
    int last;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0; last_addr = '0;
    repeat (3) @(negedge clk);
    chk("in_reset_outputs", {alu_a, alu_b, alu_ctrl, alu_reg_addr, alu_reg_write, busy, pc, seq_done, retired, timeout_err}, 32'd0);
    #1 reset = 1'b0;
    wait_neg();
    chk("post_reset_outputs", {alu_a, alu_b, alu_ctrl, alu_reg_addr, alu_reg_write, busy, pc, seq_done, retired, timeout_err}, 32'd0);

    // ADD 2+3 -> r0, done three cycles into EXEC
    load(0, 8'b00_10_11_00);
    alu_mode = 0; alu_lat = 3;
    run(0, 1, 1'b1, 1'b0, 50);
    chk("t1_alu_a", alu_a, 2'd2);
    chk("t1_alu_b", alu_b, 2'd3);
    chk("t1_retired", retired, 1);

    // ADD 2+1 -> r0, SUB 3-1 -> r1
    load(0, 8'b00_10_01_00);
    load(1, 8'b01_11_01_01);
    alu_lat = $urandom_range(2, 4);
    run(1, 2, 1'b1, 1'b0, 60);
    chk("t2_pc", pc, 1);
    chk("t2_retired", retired, 2);

    // alu_done held high: every EXEC lasts exactly two cycles
    for (int i = 0; i < 4; i++) load(i, 8'($urandom()));
    alu_mode = 1;
    run(3, 4, 1'b1, 1'b0, 100);
    alu_mode = 0;

    // random programs and latencies, including a full-memory run
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) load(i, 8'($urandom()));
      last = (r == 0) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1);
      alu_lat = $urandom_range(2, 5);
      run(last, last + 1, 1'b1, 1'b0, 400);
      chk("rand_retired", retired, last + 1);
      chk("rand_pc", pc, last);
    end

    // abort together with done in EXEC of instruction 1 of 3; prog_we/start pulses ignored
    for (int i = 0; i < 3; i++) load(i, 8'($urandom()));
    alu_lat = 3;
    abort_arm = 1'b1;
    run(2, 2, 1'b0, 1'b1, 100);
    abort_arm = 1'b0;
    chk("abort_retired", retired, 1);
    chk("abort_reg_write", alu_reg_write, 1'b0);
    chk("abort_busy", busy, 1'b0);
    run(2, 3, 1'b1, 1'b0, 100);
    chk("rerun_retired", retired, 3);

    // asynchronous reset between clock edges in the middle of EXEC
    for (int i = 0; i < 4; i++) load(i, 8'($urandom()));
    alu_lat = 5;
    expect_prog(3, 4, 1'b1);
    wait_neg();
    start = 1'b1; last_addr = AW'(3);
    wait_neg();
    start = 1'b0;
    n = 0;
    while (!(alu_reg_write && pc == 1) && n < 100) begin wait_neg(); n++; end
    if (!(alu_reg_write && pc == 1)) fail_now("reset_test_exec_not_reached");
    @(negedge clk);
    #2 reset = 1'b1;
    mon_discard = 1'b1;
    #1;
    chk("async_reset_reg_write", alu_reg_write, 1'b0);
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_pc", pc, 0);
    #1 reset = 1'b0;
    exp_q.delete();
    done_q.delete();
    alu_lat = 2;
    run(3, 4, 1'b1, 1'b0, 100);
    chk("post_reset_rerun_retired", retired, 4);

`ifdef ALU_SEQ_TIMEOUT_EN
    // watchdog: done never arrives
    alu_mode = 2;
    expect_prog(0, 1, 1'b0);
    wait_neg();
    start = 1'b1; last_addr = AW'(0);
    wait_neg();
    start = 1'b0;
    n = 0;
    while (!timeout_err && n < 40) begin wait_neg(); n++; end
    chk("timeout_flag", timeout_err, 1'b1);
    chk("timeout_reg_write", alu_reg_write, 1'b0);
    chk("timeout_busy", busy, 1'b1);
    abort_req = 1'b1;
    wait_neg();
    wait_neg();
    chk("timeout_abort_idle", busy, 1'b0);
    chk("timeout_flag_sticky", timeout_err, 1'b1);
    alu_mode = 0; alu_lat = 2;
    run(0, 1, 1'b1, 1'b0, 50);
    chk("timeout_cleared_by_start", timeout_err, 1'b0);
`else
    chk("timeout_err_tied_low", timeout_err, 1'b0);
`endif

    repeat (3) wait_neg();
    chk("exec_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_watchdog (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
